// File: rtl/sliced_adder_sequencer.sv
// Multi-cycle add/subtract: one SLICE-bit ripple adder slice is stepped across
// WIDTH-bit operands, one slice per clock, with a registered carry between slices.
module sliced_adder_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carryout_q, carryout_d;
  logic              overflow_q, overflow_d;

  logic [SLICE-1:0]  slice_a, slice_b;
  logic [SLICE:0]    slice_res;

  // Operand slice selection by comparing against constants keeps the
  // part-selects static, so the shared slice adder sees a plain mux.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        slice_a = opa_q[i*SLICE +: SLICE];
        slice_b = opb_q[i*SLICE +: SLICE];
      end
    end
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) begin
            acc_d[i*SLICE +: SLICE] = slice_res[SLICE-1:0];
          end
        end
        carry_d = slice_res[SLICE];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // acc_d already holds the final slice, so it is the complete result.
          sum_d      = acc_d;
          carryout_d = slice_res[SLICE];
          overflow_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                       (acc_d[WIDTH-1] != opa_q[WIDTH-1]);
          idx_d      = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sliced_adder_sequencer.sv
// Directed bench for sliced_adder_sequencer: hand-computed add/subtract vectors,
// handshake timing, input-change immunity and asynchronous reset abort.
module tb_sliced_adder_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carryout;
  logic        overflow;

  int tests  = 0;
  int failed = 0;
  logic [15:0] last_sum = 16'h0000;

  sliced_adder_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, watch 8 samples, then check timing and results.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tsub, input logic [15:0] esum, input logic eco,
                        input logic eov);
    int busy_n, done_at, done_n, hold_err;
    logic [15:0] rsum;
    logic rco, rov;
    busy_n = 0; done_at = -1; done_n = 0; hold_err = 0;
    rsum = '0; rco = 1'b0; rov = 1'b0;
    @(negedge clk);
    a = ta; b = tbv; op_sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tbv; op_sub = ~tsub;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i; rsum = sum; rco = carryout; rov = overflow;
        end
      end else if (done_at < 0 && sum !== last_sum) begin
        hold_err++;
      end
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, busy_n, 4);
    check({tag, ".done_at"}, done_at, 4);
    check({tag, ".done_pulses"}, done_n, 1);
    check({tag, ".sum_hold"}, hold_err, 0);
    check({tag, ".sum"}, rsum, esum);
    check({tag, ".carryout"}, rco, eco);
    check({tag, ".overflow"}, rov, eov);
    check({tag, ".sum_after"}, sum, esum);
    $display("[TB] %s a=%h b=%h sub=%0d -> sum=%h co=%0d ov=%0d", tag, ta, tbv, tsub, rsum, rco, rov);
    last_sum = esum;
  endtask

  initial begin
    int done_n;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    #12;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.sum", sum, 0);
    check("reset.carryout", carryout, 0);
    check("reset.overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_add_1_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op("t2_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t3_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t3_neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("t4_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Test 5: input churn during RUN and DONE, held start re-accepted from IDLE.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      check("t5.busy_run", busy, 1);
      check("t5.sum_hold", sum, last_sum);
      if (done) done_n++;
      start = i[0]; a = 16'hFFFF; b = 16'hFFFF;
      @(negedge clk);
    end
    check("t5.done", done, 1);
    check("t5.sum", sum, 16'h2345);
    check("t5.carryout", carryout, 0);
    check("t5.overflow", overflow, 0);
    $display("[TB] t5_churn a=1234 b=1111 -> sum=%h co=%0d ov=%0d", sum, carryout, overflow);
    start = 1'b1;
    @(negedge clk);
    check("t5.idle_busy", busy, 0);
    check("t5.idle_done", done, 0);
    check("t5.pulses", done_n, 0);
    @(negedge clk);
    check("t5.reaccept", busy, 1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("t5.second_busy", busy, 1);
    @(negedge clk);
    check("t5.second_done", done, 1);
    check("t5.second_sum", sum, 16'hFFFE);
    check("t5.second_co", carryout, 1);
    check("t5.second_ov", overflow, 0);
    $display("[TB] t5_second a=FFFF b=FFFF -> sum=%h co=%0d ov=%0d", sum, carryout, overflow);
    last_sum = 16'hFFFE;

    // Test 6: asynchronous reset two cycles into RUN.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6.busy0", busy, 1);
    @(negedge clk);
    check("t6.busy1", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_busy", busy, 0);
    check("t6.rst_done", done, 0);
    check("t6.rst_sum", sum, 0);
    check("t6.rst_co", carryout, 0);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("t6.no_done", done_n, 0);
    $display("[TB] t6_reset_abort sum=%h busy=%0d done_pulses=%0d", sum, busy, done_n);
    rst_n = 1'b1;
    last_sum = 16'h0000;
    run_op("t6_after", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
